if_stage: RTL
=============

# if_stage

Instruction fetch stage of the RI5CY-style pipeline, sitting directly upstream of the decode stage. Owns the program counter, issues word fetches over a req/gnt/rvalid instruction-memory port, buffers returned words in a small prefetch FIFO, and presents instruction, PC and PC+4 to decode. Handles branch/jump redirects from downstream by flushing buffered and in-flight fetches.

## Interface
- WORD_WIDTH, 32, instruction/address width
- BOOT_ADDR, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 2, prefetch entries (power of two, ≥2); also the cap on stored + outstanding fetches

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instr_req_o  out  1  fetch request
- instr_addr_o  out  WORD_WIDTH  fetch address, word aligned
- instr_gnt_i  in  1  request accepted this cycle
- instr_rvalid_i  in  1  response data valid, in order, ≥1 cycle after its gnt
- instr_rdata_i  in  WORD_WIDTH  response word
- redirect_i  in  1  branch/jump taken; flush and refetch
- redirect_pc_i  in  WORD_WIDTH  redirect target (bits [1:0] ignored, forced 0)
- stall_i  in  1  decode cannot accept this cycle
- instr_valid_o  out  1  instruction_o/pc_o/pc_plus4_o valid
- instruction_o  out  WORD_WIDTH  FIFO head instruction; 32'h0000_0013 (NOP) when empty
- pc_o  out  WORD_WIDTH  PC of head; 0 when empty
- pc_plus4_o  out  WORD_WIDTH  pc_o + 4 (mod 2^WORD_WIDTH); 0 when empty

## Operation
- State: fetch_addr, FIFO of {instr, pc} with count, outstanding counter (granted, no rvalid yet), discard counter, pending_stale flag.
- Pop: instr_valid_o && !stall_i && !redirect_i. Outputs are first-word-fall-through from FIFO head.
- Issue: instr_req_o = 1 when count + outstanding − pop < FIFO_DEPTH, or when a request is already pending ungranted. Once asserted, req and addr held stable until gnt (never retracted).
- On gnt: fetch_addr += 4 (wraps), outstanding += 1.
- On rvalid: outstanding −= 1; if discard > 0, discard −= 1 and word dropped; else push {rdata, pc of that fetch}. PC of each in-flight fetch tracked in order (rd PC = fetch PC of oldest outstanding).
- Redirect in cycle T: FIFO flushed; fetch_addr ← redirect_pc_i; discard ← outstanding after cycle T (includes a gnt in T, excludes an rvalid in T, which is itself dropped). If a request is pending ungranted in T, it stays on the bus with old address; pending_stale set; on its gnt, discard += 1 and fetch_addr not incremented. Next request uses the target.
- Redirect wins over pop, push and a simultaneous redirect-free gnt update of fetch_addr.
- Back-to-back redirects: each reloads fetch_addr and adds to discard as above; no stale word ever reaches the FIFO.
- Push and pop in same cycle with FIFO full: legal only by the issue rule; overflow never occurs. Bench asserts count ≤ FIFO_DEPTH.

## Timing
- Reset (rst high at edge): fetch_addr = BOOT_ADDR, count = outstanding = discard = 0, pending_stale = 0. Outputs during/after reset: instr_req_o 0 while rst high, instr_valid_o 0, instruction_o NOP, pc_o 0, pc_plus4_o 0.
- First cycle with rst low: instr_req_o 1, instr_addr_o = BOOT_ADDR.
- Latency: gnt in cycle N, rvalid in N+1 → instr_valid_o in N+2.
- Throughput: 1 instruction/cycle sustained with 1-cycle memory and no stall.
- Redirect in T: instr_valid_o 0 from T+1; req to target earliest T+1; with gnt T+1, rvalid T+2 → valid T+3.
- Reset mid-operation: all state cleared at that edge; responses to pre-reset grants are the memory's responsibility (memory reset together).

## Test plan
- Boot: release rst, memory grants immediately, rvalid 1 cycle later → addrs 0x0,0x4,0x8…; instr_valid_o from cycle 3; pc_plus4_o = pc_o+4; one instruction per cycle.
- Stall: stall_i high 5 cycles → FIFO holds 2 entries, instr_req_o drops when count+outstanding = 2; on release, pc_o sequence continues with no gap or duplicate.
- Redirect with 2 responses in flight (rvalid latency 3) to 0x100 → both stale words dropped; first valid instruction has pc_o = 0x100.
- Redirect while req pending ungranted (gnt withheld 4 cycles at addr 0x8) → addr 0x8 held until gnt, its response discarded, next request addr = 0x200.
- Redirect concurrent with stall and rvalid, then second redirect next cycle to 0x300 → only 0x300-stream instructions appear.
- rst asserted mid-stream with FIFO full → next cycle instr_valid_o 0, instruction_o 0x0000_0013, first request addr BOOT_ADDR.

Source files
------------

// File: rtl/if_stage_if.sv
// Bundle of the instruction-memory port and the decode-side handshake of the fetch stage.
interface if_stage_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  instr_req_o;
  logic [WORD_WIDTH-1:0] instr_addr_o;
  logic                  instr_gnt_i;
  logic                  instr_rvalid_i;
  logic [WORD_WIDTH-1:0] instr_rdata_i;
  logic                  redirect_i;
  logic [WORD_WIDTH-1:0] redirect_pc_i;
  logic                  stall_i;
  logic                  instr_valid_o;
  logic [WORD_WIDTH-1:0] instruction_o;
  logic [WORD_WIDTH-1:0] pc_o;
  logic [WORD_WIDTH-1:0] pc_plus4_o;

  modport master (
    output instr_req_o, instr_addr_o, instr_valid_o, instruction_o, pc_o, pc_plus4_o,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, redirect_i, redirect_pc_i, stall_i
  );

  modport slave (
    input  instr_req_o, instr_addr_o, instr_valid_o, instruction_o, pc_o, pc_plus4_o,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i, redirect_i, redirect_pc_i, stall_i
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC generation, req/gnt/rvalid fetch port, prefetch FIFO with
// first-word-fall-through to decode, and redirect flushing of buffered and in-flight words.
module if_stage #(
  parameter int                     WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0]  BOOT_ADDR  = '0,
  parameter int                     FIFO_DEPTH = 2
) (
  input logic       clk,
  input logic       rst,
  if_stage_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [WORD_WIDTH-1:0] NOP = WORD_WIDTH'(32'h0000_0013);

  logic [WORD_WIDTH-1:0] fetch_addr;
  logic [WORD_WIDTH-1:0] pend_addr;
  logic                  req_pending;
  logic                  pending_stale;

  logic [WORD_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] fifo_pc    [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;

  logic [WORD_WIDTH-1:0] flight_pc  [FIFO_DEPTH];
  logic [PW-1:0]         flight_rd, flight_wr;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         discard;

  logic                  valid, pop, push, drop, issue_ok, req, gnt_fire, rvalid;
  logic [CW:0]           occupancy;
  logic [CW-1:0]         outstanding_next;
  logic [WORD_WIDTH-1:0] req_addr;

  // Issue while stored + in-flight fetches (less this cycle's pop) leave room in the FIFO;
  // an ungranted request stays on the bus regardless so it is never retracted.
  always_comb begin
    valid            = (count != '0) && !rst;
    pop              = valid && !bus.stall_i && !bus.redirect_i;
    occupancy        = {1'b0, count} + {1'b0, outstanding};
    issue_ok         = occupancy < ((CW+1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop});
    req              = !rst && (req_pending || issue_ok);
    req_addr         = req_pending ? pend_addr : fetch_addr;
    gnt_fire         = req && bus.instr_gnt_i;
    rvalid           = bus.instr_rvalid_i;
    drop             = bus.redirect_i || (discard != '0);
    push             = rvalid && !drop;
    outstanding_next = outstanding + CW'(gnt_fire) - CW'(rvalid);
  end

  assign bus.instr_req_o   = req;
  assign bus.instr_addr_o  = req_addr;
  assign bus.instr_valid_o = valid;
  assign bus.instruction_o = valid ? fifo_instr[rd_ptr] : NOP;
  assign bus.pc_o          = valid ? fifo_pc[rd_ptr] : '0;
  assign bus.pc_plus4_o    = valid ? fifo_pc[rd_ptr] + WORD_WIDTH'(4) : '0;

  // A redirect overrides pop, push and the post-grant address increment; words already
  // granted at that point are counted into discard and dropped as they return.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr    <= BOOT_ADDR;
      pend_addr     <= '0;
      req_pending   <= 1'b0;
      pending_stale <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      flight_rd     <= '0;
      flight_wr     <= '0;
      outstanding   <= '0;
      discard       <= '0;
    end else begin
      outstanding <= outstanding_next;
      req_pending <= req && !bus.instr_gnt_i;
      if (req && !bus.instr_gnt_i) pend_addr <= req_addr;
      if (gnt_fire) begin
        flight_pc[flight_wr] <= req_addr;
        flight_wr            <= flight_wr + PW'(1);
      end
      if (rvalid) flight_rd <= flight_rd + PW'(1);

      if (bus.redirect_i) begin
        fetch_addr    <= {bus.redirect_pc_i[WORD_WIDTH-1:2], 2'b00};
        rd_ptr        <= '0;
        wr_ptr        <= '0;
        count         <= '0;
        discard       <= outstanding_next;
        pending_stale <= req && !bus.instr_gnt_i;
      end else begin
        if (gnt_fire && !pending_stale) fetch_addr <= fetch_addr + WORD_WIDTH'(4);
        if (gnt_fire) pending_stale <= 1'b0;
        discard <= discard - CW'(rvalid && (discard != '0)) + CW'(gnt_fire && pending_stale);
        if (push) begin
          fifo_instr[wr_ptr] <= bus.instr_rdata_i;
          fifo_pc[wr_ptr]    <= flight_pc[flight_rd];
          wr_ptr             <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule
